dmem_line_responder: RTL

- Memory-side responder for the 256-bit line-transfer interface driven by the dcache miss/write-back engine inside CPU.
- Accepts one read or write line request at a time and returns `ack_o` after a fixed, parameterised latency.
- Replaces the behavioural data memory in system benches.
- Backing store: 512 lines x 256 bits (16 KB), addressed by line.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_line_responder_if.sv | 23 ++
 rtl/dmem_line_array.sv | 43 ++++
 rtl/dmem_line_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and line-index helper for the line-transfer responder.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Byte address to line index; callers truncate to their own index width, so upper bits alias.
  function automatic logic [ADDR_W-1:0] line_idx(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned      idx_w);
    return (addr >> OFFSET_W) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Line-transfer bus between the dcache miss/write-back engine (master) and memory (slave).
interface dmem_line_responder_if #(
  parameter int LINE_W = dmem_pkg::LINE_W
);

  logic [dmem_pkg::ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0]           data_i;
  logic                        enable_i;
  logic                        write_i;
  logic                        ack_o;
  logic [LINE_W-1:0]           data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/dmem_line_array.sv
// Single-port DEPTH x LINE_W line store with a registered read port; contents are never reset.
module dmem_line_array #(
  parameter int DEPTH  = 512,
  parameter int LINE_W = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] memory [DEPTH];
  logic [LINE_W-1:0] rdata_d, rdata_q;

  // Read data holds between reads so the line stays visible after the ack.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = memory[idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency memory responder for 256-bit line reads/writes, one request at a time.
// Optional DMEM_STATS_EN adds saturating read/write completion counters.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = dmem_pkg::LINE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dmem_line_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [LINE_W-1:0] wdata_d, wdata_q;
  logic              wr_d, wr_q;
  logic              mem_we, mem_re;

  // Every request, including LATENCY = 1, spends LATENCY edges in BUSY before ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          idx_d   = IDX_W'(line_idx(bus.addr_i, IDX_W));
          wdata_d = bus.data_i;
          wr_d    = bus.write_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          // A reset on this edge aborts the request, so the array must not see it.
          mem_we  = wr_q & ~rst_i;
          mem_re  = ~wr_q & ~rst_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    wdata_q <= wdata_d;
  end

  dmem_line_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.data_o)
  );

  assign bus.ack_o = (state_q == ACK);

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_d, rd_cnt_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (mem_re && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (mem_we && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
